// File: rtl/acc_drain.sv
// rtl/acc_drain.sv - accumulator requantize, saturate and frame-ordered output FIFO
//
// Purpose: takes 22-bit signed accumulator sums, rounds and shifts them down,
// saturates to 8 bits (optionally with ReLU), and queues the results in a small
// FIFO with a per-entry frame-last marker. Once the last sum of a frame has been
// written, no new input is admitted until that last entry has drained.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   din         signed 22-bit accumulator sum
//   din_valid   din holds a new sum
//   din_ready   block can accept din this cycle (registered state only)
//   dout        signed 8-bit requantized result (FIFO head, 0 when empty)
//   dout_valid  FIFO not empty
//   dout_ready  downstream accepts dout
//   dout_last   head entry is the final result of its frame
//   sat_flag    sticky: some accepted sum saturated

module acc_drain #(
    parameter int SHIFT = 6,
    parameter int RELU  = 1,
    parameter int DEPTH = 4,
    parameter int NOUT  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_last,
    output logic        sat_flag
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [22:0] RND = 23'(1) << (SHIFT - 1);

    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_mem [DEPTH];
    logic [DEPTH-1:0]   r_last_bits;
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic [7:0]         r_frame;
    logic               r_sat;

    logic [22:0]        w_sum;
    logic signed [22:0] w_r;
    logic               w_hi;
    logic               w_lo;
    logic [7:0]         w_q;
    logic               w_push;
    logic               w_pop;
    logic               w_frame_end;

    // Round half up, then arithmetic shift; 23 bits cannot overflow on the add.
    assign w_sum = {din[21], din} + RND;
    assign w_r   = $signed(w_sum) >>> SHIFT;
    assign w_hi  = (w_r > 23'sd127);
    assign w_lo  = (w_r < -23'sd128);

    // ReLU clamping of an in-range negative value is not a saturation event.
    always_comb begin
        w_q = w_r[7:0];
        if (w_hi) begin
            w_q = 8'h7f;
        end else if ((RELU != 0) && w_r[22]) begin
            w_q = 8'h00;
        end else if (w_lo) begin
            w_q = 8'h80;
        end
    end

    assign din_ready   = (r_state == FILL) && (r_count < CW'(DEPTH));
    assign dout_valid  = (r_count != '0);
    // Gate with valid so stale FIFO contents never show after reset.
    assign dout        = dout_valid ? r_mem[r_rptr] : 8'h00;
    assign dout_last   = dout_valid & r_last_bits[r_rptr];
    assign sat_flag    = r_sat;

    assign w_push      = din_valid & din_ready;
    assign w_pop       = dout_valid & dout_ready;
    assign w_frame_end = (r_frame == 8'(NOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL:    if (w_push && w_frame_end) w_state_nxt = FLUSH;
            FLUSH:   if (w_pop && r_last_bits[r_rptr]) w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_frame <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_wptr  <= r_wptr + 1'b1;
                r_frame <= w_frame_end ? 8'd0 : r_frame + 8'd1;
                if (w_hi || w_lo) r_sat <= 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset: entries are invisible until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr]       <= w_q;
            r_last_bits[r_wptr] <= w_frame_end;
        end
    end

endmodule
